pcie_byte_striper: RTL and testbench



---
 rtl/pcie_byte_striper.sv | 121 ++++++++++++
 tb/tb_pcie_byte_striper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_byte_striper.sv
// rtl/pcie_byte_striper.sv - round-robin byte striper from one link-layer byte stream onto num_lanes lanes
// Optional feature macro: STRIPER_PAD_EN (pad unused lanes of a short symbol time with K23.7 instead of idle).
module pcie_byte_striper #(
    parameter int num_lanes = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_k,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*num_lanes-1:0] lane_data,
    output logic [num_lanes-1:0]   lane_k,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int IW = (num_lanes > 1) ? $clog2(num_lanes) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(num_lanes - 1);

`ifdef STRIPER_PAD_EN
    localparam logic [7:0] PAD_DATA = 8'hF7;
    localparam logic       PAD_K    = 1'b1;
`else
    localparam logic [7:0] PAD_DATA = 8'h00;
    localparam logic       PAD_K    = 1'b0;
`endif

    logic [IW-1:0]          lane_idx_q, lane_idx_d;
    logic [8*num_lanes-1:0] acc_data_q, acc_data_d;
    logic [num_lanes-1:0]   acc_k_q, acc_k_d;
    logic [8*num_lanes-1:0] out_data_q, out_data_d;
    logic [num_lanes-1:0]   out_k_q, out_k_d;
    logic                   out_valid_q, out_valid_d;

    logic                   completing;
    logic                   accept;
    logic [8*num_lanes-1:0] sym_data;
    logic [num_lanes-1:0]   sym_k;

    always_comb begin
        completing = (lane_idx_q == LAST_IDX) || in_last;
        in_ready   = !(completing && out_valid_q && !out_ready);
        accept     = in_valid && in_ready;
    end

    // Symbol time as it would look if the current byte closed it.
    always_comb begin
        sym_data = '0;
        sym_k    = '0;
        for (int i = 0; i < num_lanes; i++) begin
            if (i < int'(lane_idx_q)) begin
                sym_data[8*i +: 8] = acc_data_q[8*i +: 8];
                sym_k[i]           = acc_k_q[i];
            end else if (i == int'(lane_idx_q)) begin
                sym_data[8*i +: 8] = in_data;
                sym_k[i]           = in_k;
            end else begin
                sym_data[8*i +: 8] = PAD_DATA;
                sym_k[i]           = PAD_K;
            end
        end
    end

    always_comb begin
        lane_idx_d  = lane_idx_q;
        acc_data_d  = acc_data_q;
        acc_k_d     = acc_k_q;
        out_data_d  = out_data_q;
        out_k_d     = out_k_q;
        out_valid_d = out_valid_q;

        // Clearing on consume keeps the lanes at logical idle without an output mux.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_k_d     = '0;
        end

        if (accept) begin
            if (completing) begin
                out_valid_d = 1'b1;
                out_data_d  = sym_data;
                out_k_d     = sym_k;
                lane_idx_d  = '0;
            end else begin
                for (int i = 0; i < num_lanes; i++) begin
                    if (i == int'(lane_idx_q)) begin
                        acc_data_d[8*i +: 8] = in_data;
                        acc_k_d[i]           = in_k;
                    end
                end
                lane_idx_d = lane_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx_q  <= '0;
            acc_data_q  <= '0;
            acc_k_q     <= '0;
            out_data_q  <= '0;
            out_k_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            lane_idx_q  <= lane_idx_d;
            acc_data_q  <= acc_data_d;
            acc_k_q     <= acc_k_d;
            out_data_q  <= out_data_d;
            out_k_q     <= out_k_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign lane_data = out_data_q;
    assign lane_k    = out_k_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pcie_byte_striper.sv
// tb/tb_pcie_byte_striper.sv - scoreboard bench for pcie_byte_striper with 4 lanes
module tb_pcie_byte_striper;

    localparam int NL = 4;

`ifdef STRIPER_PAD_EN
    localparam logic [7:0] PAD_D = 8'hF7;
    localparam logic       PAD_K = 1'b1;
`else
    localparam logic [7:0] PAD_D = 8'h00;
    localparam logic       PAD_K = 1'b0;
`endif

    typedef struct packed {
        logic [8*NL-1:0] d;
        logic [NL-1:0]   k;
    } sym_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = '0;
    logic              in_k = 1'b0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8*NL-1:0]   lane_data;
    logic [NL-1:0]     lane_k;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    sym_t       exp_q[$];
    logic [7:0] cur_d[$];
    logic       cur_k[$];

    pcie_byte_striper #(.num_lanes(NL)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_k(in_k), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_data(lane_data), .lane_k(lane_k),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: bytes gather per symbol time; a full set of NL bytes or in_last closes it.
    task automatic model_accept(input logic [7:0] d, input logic k, input logic last);
        sym_t s;
        cur_d.push_back(d);
        cur_k.push_back(k);
        if (cur_d.size() == NL || last) begin
            for (int i = 0; i < NL; i++) begin
                if (i < cur_d.size()) begin
                    s.d[8*i +: 8] = cur_d[i];
                    s.k[i]        = cur_k[i];
                end else begin
                    s.d[8*i +: 8] = PAD_D;
                    s.k[i]        = PAD_K;
                end
            end
            exp_q.push_back(s);
            cur_d.delete();
            cur_k.delete();
        end
    endtask

    task automatic send(input logic [7:0] d, input logic k, input logic last);
        logic exp_rdy;
        in_data  = d;
        in_k     = k;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            exp_rdy = !((cur_d.size() == NL - 1 || last) && exp_q.size() > 0 && !out_ready);
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            @(posedge clk);
            if (exp_rdy) begin
                model_accept(d, k, last);
                #1;
                return;
            end
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted, expected acceptance within 200 cycles", d);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_d.delete();
        cur_k.delete();
        exp_q.delete();
    endtask

    // Monitor: compares presented symbol times, pops on consumption.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol: got %0h/%0h expected none", lane_data, lane_k);
                end else begin
                    check("lane_data", 64'(lane_data), 64'(exp_q[0].d));
                    check("lane_k", 64'(lane_k), 64'(exp_q[0].k));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_data", 64'({lane_k, lane_data}), 64'(0));
                if (exp_q.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_symbol: out_valid 0 expected symbol %0h", exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_lane_data", 64'(lane_data), 64'(0));
            check("reset_lane_k", 64'(lane_k), 64'(0));
            check("reset_in_ready", 64'(in_ready), 64'(1));
        end
        @(posedge clk);
        #1;

        send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0);
        idle(3);

        send(8'hFB, 1, 0); send(8'h01, 0, 0); send(8'h02, 0, 1);
        idle(3);

        for (int i = 0; i < 8; i++) send(8'(i), 0, 0);
        idle(3);

        // in_last on the final slot must not add an extra symbol time
        send(8'h5A, 0, 0); send(8'h5B, 1, 0); send(8'h5C, 0, 0); send(8'h5D, 0, 1);
        idle(3);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), 0, 0);
        for (int i = 4; i < 7; i++) send(8'h80 + 8'(i), 0, 0);
        fork
            send(8'h87, 0, 0);
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        send(8'hEE, 0, 0); send(8'hEF, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 0, 0);
        idle(3);

        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(8'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        send(8'hC0, 0, 1);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
